// File: rtl/song_sequencer_if.sv
// ------------------------------------------------------------------
// song_sequencer_if: play controls, song ROM and note-player bundle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface song_sequencer_if #(
  parameter int SONG_BITS  = 2,
  parameter int IDX_BITS   = 5,
  parameter int NUM_VOICES = 3
);
  logic                          play;
  logic [SONG_BITS-1:0]          song;
  logic                          beat;
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
  logic [15:0]                   rom_dout;
  logic [NUM_VOICES-1:0]         voice_busy;
  logic [NUM_VOICES-1:0]         note_load;
  logic [5:0]                    note;
  logic [5:0]                    duration;
  logic [2:0]                    meta;
  logic                          playing;
  logic                          song_done;

  modport master (
    input  play, song, beat, rom_dout, voice_busy,
    output rom_addr, note_load, note, duration, meta, playing, song_done
  );

  modport slave (
    output play, song, beat, rom_dout, voice_busy,
    input  rom_addr, note_load, note, duration, meta, playing, song_done
  );
endinterface

`default_nettype wire

// File: rtl/song_sequencer.sv
// ------------------------------------------------------------------
// song_sequencer: song ROM playback, note dispatch and beat timing
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module song_sequencer #(
  parameter int SONG_BITS  = 2,
  parameter int IDX_BITS   = 5,
  parameter int NUM_VOICES = 3
) (
  input  wire logic          clk,
  input  wire logic          reset,
  song_sequencer_if.master   bus
);

  localparam int c_ptr_bits = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [c_ptr_bits-1:0] c_last_voice = c_ptr_bits'(NUM_VOICES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SONG_BITS-1:0]   song_q, song_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [c_ptr_bits-1:0]  steal_ptr_q, steal_ptr_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [5:0]             note_q, note_d;
  logic [5:0]             dur_q, dur_d;
  logic [2:0]             meta_q, meta_d;
  logic                   done_q, done_d;

  logic                   w_wait_flag;
  logic [5:0]             w_note;
  logic [5:0]             w_dur;
  logic [2:0]             w_meta;
  logic                   w_song_changed;
  logic                   w_last_idx;
  logic                   w_free_found;
  logic [c_ptr_bits-1:0]  w_free_idx;
  logic [c_ptr_bits-1:0]  w_sel_idx;
  logic [NUM_VOICES-1:0]  w_onehot;
  logic                   w_load;

  assign w_wait_flag    = bus.rom_dout[15];
  assign w_note         = bus.rom_dout[14:9];
  assign w_dur          = bus.rom_dout[8:3];
  assign w_meta         = bus.rom_dout[2:0];
  assign w_song_changed = (bus.song != song_q);
  assign w_last_idx     = (idx_q == {IDX_BITS{1'b1}});

  // Scan from the top down so the lowest idle voice wins.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!bus.voice_busy[v]) begin
        w_free_found = 1'b1;
        w_free_idx   = v[c_ptr_bits-1:0];
      end
    end
  end

  assign w_sel_idx = w_free_found ? w_free_idx : steal_ptr_q;

  always_comb begin
    w_onehot = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_onehot[v] = (w_sel_idx == v[c_ptr_bits-1:0]);
    end
  end

  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    idx_d       = idx_q;
    steal_ptr_d = steal_ptr_q;
    cnt_d       = cnt_q;
    note_d      = note_q;
    dur_d       = dur_q;
    meta_d      = meta_q;
    w_load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.play) begin
          song_d  = bus.song;
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (w_song_changed) begin
          state_d = ST_IDLE;
        end else if (bus.play) begin
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (w_song_changed) begin
          state_d = ST_IDLE;
        end else if (w_wait_flag) begin
          if (w_dur != 6'd0) begin
            cnt_d   = w_dur;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          if ((w_note != 6'd0) && (w_dur != 6'd0)) begin
            w_load = 1'b1;
            note_d = w_note;
            dur_d  = w_dur;
            meta_d = w_meta;
            if (!w_free_found) begin
              steal_ptr_d = (steal_ptr_q == c_last_voice) ? '0 : steal_ptr_q + 1'b1;
            end
          end
          if (w_last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_WAIT: begin
        if (w_song_changed) begin
          state_d = ST_IDLE;
        end else if (bus.beat && bus.play) begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            if (w_last_idx) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
      end

      ST_DONE: begin
        if (!bus.play || w_song_changed) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      song_q      <= '0;
      idx_q       <= '0;
      steal_ptr_q <= '0;
      cnt_q       <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      meta_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      idx_q       <= idx_d;
      steal_ptr_q <= steal_ptr_d;
      cnt_q       <= cnt_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      meta_q      <= meta_d;
      done_q      <= done_d;
    end
  end

  // Fields come straight from the ROM on a load cycle and hold afterwards.
  assign bus.rom_addr  = {song_q, idx_q};
  assign bus.note_load = w_load ? w_onehot : '0;
  assign bus.note      = note_d;
  assign bus.duration  = dur_d;
  assign bus.meta      = meta_d;
  assign bus.playing   = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_WAIT);
  assign bus.song_done = done_q;

endmodule

`default_nettype wire
